// File: rtl/em_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : em_pipe_reg_pkg
// Brief    : Shared widths, control-bundle type and alignment helper for the
//            EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
package em_pipe_reg_pkg;

    localparam int DEF_LEN_WORD          = 32;
    localparam int DEF_LEN_REG_FILE_ADDR = 5;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK_WORD = 2'b11;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic forward_wb_m;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_misaligned(
        input logic       valid,
        input logic       mem_read,
        input logic       mem_write,
        input logic [1:0] addr_lsb
    );
        return valid && (mem_read || mem_write) &&
               ((addr_lsb & ALIGN_MASK_WORD) != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/em_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : em_pipe_reg_if
// Brief    : EStage-side inputs and MStage-side outputs of the EX/MEM register.
// Revision : 1.0
// ============================================================================
interface em_pipe_reg_if #(
    parameter int LEN_WORD          = em_pipe_reg_pkg::DEF_LEN_WORD,
    parameter int LEN_REG_FILE_ADDR = em_pipe_reg_pkg::DEF_LEN_REG_FILE_ADDR
);

    logic                         stall;
    logic                         flush;

    logic                         e_valid;
    logic                         e_mem_read;
    logic                         e_mem_write;
    logic                         e_reg_write;
    logic                         e_mem_to_reg;
    logic                         e_forward_wb_m;
    logic [LEN_REG_FILE_ADDR-1:0] e_write_reg;
    logic [LEN_WORD-1:0]          e_alu_out;
    logic [LEN_WORD-1:0]          e_write_data_mem;
    logic [LEN_WORD-1:0]          e_pc;

    logic                         m_valid;
    logic                         m_mem_read;
    logic                         m_mem_write;
    logic                         m_reg_write;
    logic                         m_mem_to_reg;
    logic                         m_forward_wb_m;
    logic [LEN_REG_FILE_ADDR-1:0] m_write_reg;
    logic [LEN_WORD-1:0]          m_alu_out;
    logic [LEN_WORD-1:0]          m_write_data_mem;
    logic [LEN_WORD-1:0]          m_pc;

    logic                         addr_exc;
    logic [LEN_WORD-1:0]          addr_exc_pc;

    modport master (
        output stall, flush,
        output e_valid, e_mem_read, e_mem_write, e_reg_write, e_mem_to_reg,
               e_forward_wb_m, e_write_reg, e_alu_out, e_write_data_mem, e_pc,
        input  m_valid, m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg,
               m_forward_wb_m, m_write_reg, m_alu_out, m_write_data_mem, m_pc,
        input  addr_exc, addr_exc_pc
    );

    modport slave (
        input  stall, flush,
        input  e_valid, e_mem_read, e_mem_write, e_reg_write, e_mem_to_reg,
               e_forward_wb_m, e_write_reg, e_alu_out, e_write_data_mem, e_pc,
        output m_valid, m_mem_read, m_mem_write, m_reg_write, m_mem_to_reg,
               m_forward_wb_m, m_write_reg, m_alu_out, m_write_data_mem, m_pc,
        output addr_exc, addr_exc_pc
    );

endinterface
`default_nettype wire

// File: rtl/pipe_field_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_field_reg
// Brief    : Pipeline field register with sync active-low reset, clear, hold.
// Revision : 1.0
// ============================================================================
module pipe_field_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_hold,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear outranks hold so a flush always wins over a simultaneous stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/em_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : em_pipe_reg
// Brief    : EX/MEM pipeline register with stall/flush and misaligned-access squash.
// Revision : 1.0
// ============================================================================
module em_pipe_reg
    import em_pipe_reg_pkg::*;
#(
    parameter int LEN_WORD          = DEF_LEN_WORD,
    parameter int LEN_REG_FILE_ADDR = DEF_LEN_REG_FILE_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    em_pipe_reg_if.slave  bus
);

    localparam int DATA_W = LEN_REG_FILE_ADDR + 2 * LEN_WORD;

    logic                         w_misaligned;
    logic                         w_load;
    ctrl_t                        w_ctrl_d;
    ctrl_t                        w_ctrl_q;
    logic [DATA_W-1:0]            w_data_d;
    logic [DATA_W-1:0]            w_data_q;
    logic [LEN_WORD-1:0]          w_pc_q;

    logic                         r_addr_exc;
    logic [LEN_WORD-1:0]          r_addr_exc_pc;

    assign w_misaligned = is_misaligned(bus.e_valid, bus.e_mem_read,
                                        bus.e_mem_write, bus.e_alu_out[1:0]);
    assign w_load       = !bus.flush && !bus.stall;

    // A bubble carries no side effects; a squashed access must not touch
    // memory or the register file, and is no longer a valid instruction.
    always_comb begin
        w_ctrl_d              = '0;
        w_ctrl_d.valid        = bus.e_valid && !w_misaligned;
        w_ctrl_d.mem_read     = bus.e_valid && bus.e_mem_read  && !w_misaligned;
        w_ctrl_d.mem_write    = bus.e_valid && bus.e_mem_write && !w_misaligned;
        w_ctrl_d.reg_write    = bus.e_valid && bus.e_reg_write && !w_misaligned;
        w_ctrl_d.mem_to_reg   = bus.e_valid && bus.e_mem_to_reg;
        w_ctrl_d.forward_wb_m = bus.e_valid && bus.e_forward_wb_m;
    end

    assign w_data_d = {bus.e_write_reg, bus.e_alu_out, bus.e_write_data_mem};

    pipe_field_reg #(
        .WIDTH (CTRL_W)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (bus.stall),
        .i_clear (bus.flush),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_q)
    );

    pipe_field_reg #(
        .WIDTH (DATA_W)
    ) u_data (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (bus.stall),
        .i_clear (bus.flush),
        .i_d     (w_data_d),
        .o_q     (w_data_q)
    );

    pipe_field_reg #(
        .WIDTH (LEN_WORD)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (bus.stall),
        .i_clear (bus.flush),
        .i_d     (bus.e_pc),
        .o_q     (w_pc_q)
    );

    // The pulse is only raised on a real load edge, so a stall never stretches
    // it; the captured PC survives flushes and stalls until the next exception.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr_exc    <= 1'b0;
            r_addr_exc_pc <= '0;
        end else begin
            r_addr_exc <= w_load && w_misaligned;
            if (w_load && w_misaligned) begin
                r_addr_exc_pc <= bus.e_pc;
            end
        end
    end

    assign bus.m_valid          = w_ctrl_q.valid;
    assign bus.m_mem_read       = w_ctrl_q.mem_read;
    assign bus.m_mem_write      = w_ctrl_q.mem_write;
    assign bus.m_reg_write      = w_ctrl_q.reg_write;
    assign bus.m_mem_to_reg     = w_ctrl_q.mem_to_reg;
    assign bus.m_forward_wb_m   = w_ctrl_q.forward_wb_m;
    assign bus.m_write_reg      = w_data_q[DATA_W-1 -: LEN_REG_FILE_ADDR];
    assign bus.m_alu_out        = w_data_q[2*LEN_WORD-1 -: LEN_WORD];
    assign bus.m_write_data_mem = w_data_q[LEN_WORD-1:0];
    assign bus.m_pc             = w_pc_q;
    assign bus.addr_exc         = r_addr_exc;
    assign bus.addr_exc_pc      = r_addr_exc_pc;

endmodule
`default_nettype wire

// File: tb/tb_em_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_em_pipe_reg
// Brief    : Scoreboard bench for the EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
module tb_em_pipe_reg;

    localparam int LW = 32;
    localparam int LR = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    em_pipe_reg_if #(.LEN_WORD(LW), .LEN_REG_FILE_ADDR(LR)) bus();

    em_pipe_reg #(
        .LEN_WORD          (LW),
        .LEN_REG_FILE_ADDR (LR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic          mem_read;
        logic          mem_write;
        logic          reg_write;
        logic          mem_to_reg;
        logic          forward_wb_m;
        logic [LR-1:0] write_reg;
        logic [LW-1:0] alu_out;
        logic [LW-1:0] write_data_mem;
        logic [LW-1:0] pc;
        logic          addr_exc;
        logic [LW-1:0] addr_exc_pc;
    } obs_t;

    obs_t model;
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t sample();
        obs_t o;
        o.valid          = bus.m_valid;
        o.mem_read       = bus.m_mem_read;
        o.mem_write      = bus.m_mem_write;
        o.reg_write      = bus.m_reg_write;
        o.mem_to_reg     = bus.m_mem_to_reg;
        o.forward_wb_m   = bus.m_forward_wb_m;
        o.write_reg      = bus.m_write_reg;
        o.alu_out        = bus.m_alu_out;
        o.write_data_mem = bus.m_write_data_mem;
        o.pc             = bus.m_pc;
        o.addr_exc       = bus.addr_exc;
        o.addr_exc_pc    = bus.addr_exc_pc;
        return o;
    endfunction

    task automatic set_inputs(input logic v, input logic rd, input logic wr,
                              input logic rw, input logic m2r, input logic fwd,
                              input logic [LR-1:0] wreg, input logic [LW-1:0] alu,
                              input logic [LW-1:0] wdm, input logic [LW-1:0] pc);
        bus.e_valid          = v;
        bus.e_mem_read       = rd;
        bus.e_mem_write      = wr;
        bus.e_reg_write      = rw;
        bus.e_mem_to_reg     = m2r;
        bus.e_forward_wb_m   = fwd;
        bus.e_write_reg      = wreg;
        bus.e_alu_out        = alu;
        bus.e_write_data_mem = wdm;
        bus.e_pc             = pc;
    endtask

    // Predict the next state from the current inputs, queue it, clock once,
    // then compare what the DUT produced against the head of the queue.
    task automatic step(input logic rst_n, input logic st, input logic fl);
        obs_t nxt;
        obs_t act;
        obs_t exp;
        logic bad;
        nxt = model;
        if (!rst_n) begin
            nxt = '0;
        end else if (fl) begin
            nxt.valid = 0; nxt.mem_read = 0; nxt.mem_write = 0; nxt.reg_write = 0;
            nxt.mem_to_reg = 0; nxt.forward_wb_m = 0;
            nxt.write_reg = '0; nxt.alu_out = '0; nxt.write_data_mem = '0; nxt.pc = '0;
            nxt.addr_exc = 0;
        end else if (st) begin
            nxt.addr_exc = 0;
        end else begin
            bad = bus.e_valid && (bus.e_mem_read || bus.e_mem_write) &&
                  (bus.e_alu_out[1:0] != 2'b00);
            nxt.valid          = bus.e_valid && !bad;
            nxt.mem_read       = bus.e_valid && bus.e_mem_read && !bad;
            nxt.mem_write      = bus.e_valid && bus.e_mem_write && !bad;
            nxt.reg_write      = bus.e_valid && bus.e_reg_write && !bad;
            nxt.mem_to_reg     = bus.e_valid && bus.e_mem_to_reg;
            nxt.forward_wb_m   = bus.e_valid && bus.e_forward_wb_m;
            nxt.write_reg      = bus.e_write_reg;
            nxt.alu_out        = bus.e_alu_out;
            nxt.write_data_mem = bus.e_write_data_mem;
            nxt.pc             = bus.e_pc;
            nxt.addr_exc       = bad;
            if (bad) nxt.addr_exc_pc = bus.e_pc;
        end
        model = nxt;
        exp_q.push_back(nxt);
        reset     = rst_n;
        bus.stall = st;
        bus.flush = fl;
        @(posedge clk);
        #1;
        act = sample();
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, act, exp);
        end
    endtask

    task automatic test_reset();
        obs_t act;
        set_inputs(1, 1, 1, 1, 1, 1, '1, '1, '1, '1);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1);
            act = sample();
            checks++;
            if (act !== '0) begin
                errors++;
                $display("FAIL reset_zero cycle=%0d actual=%h expected=0", i, act);
            end
        end
        // All-ones address is misaligned, so release squashes it.
        step(1, 0, 0);
        checks++;
        if (bus.m_pc !== 32'hFFFF_FFFF || bus.addr_exc !== 1'b1 ||
            bus.addr_exc_pc !== 32'hFFFF_FFFF || bus.m_valid !== 1'b0 ||
            bus.m_write_reg !== 5'h1F || bus.m_mem_to_reg !== 1'b1) begin
            errors++;
            $display("FAIL reset_release actual pc=%h exc=%b exc_pc=%h valid=%b wreg=%h m2r=%b required pc=ffffffff exc=1 exc_pc=ffffffff valid=0 wreg=1f m2r=1",
                     bus.m_pc, bus.addr_exc, bus.addr_exc_pc, bus.m_valid, bus.m_write_reg, bus.m_mem_to_reg);
        end
    endtask

    task automatic test_normal_load();
        set_inputs(1, 1, 0, 1, 1, 0, 5'd5, 32'h10, 32'hABCD, 32'h40);
        step(1, 0, 0);
        checks++;
        if (bus.m_mem_read !== 1'b1 || bus.m_alu_out !== 32'h10 || bus.m_write_reg !== 5'd5 ||
            bus.m_pc !== 32'h40 || bus.addr_exc !== 1'b0 || bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL normal_load actual rd=%b alu=%h wreg=%0d pc=%h exc=%b valid=%b required rd=1 alu=10 wreg=5 pc=40 exc=0 valid=1",
                     bus.m_mem_read, bus.m_alu_out, bus.m_write_reg, bus.m_pc, bus.addr_exc, bus.m_valid);
        end
    endtask

    task automatic test_stall_flush();
        set_inputs(1, 0, 0, 1, 0, 1, 5'd9, 32'h20, 32'h1, 32'h44);
        step(1, 0, 0);
        set_inputs(1, 1, 0, 1, 1, 0, 5'd3, 32'h24, 32'h2, 32'h48);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0);
            checks++;
            if (bus.m_pc !== 32'h44 || bus.m_write_reg !== 5'd9) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d actual pc=%h wreg=%0d required pc=44 wreg=9",
                         i, bus.m_pc, bus.m_write_reg);
            end
        end
        step(1, 1, 1);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_reg_write !== 1'b0 || bus.m_forward_wb_m !== 1'b0 ||
            bus.m_mem_read !== 1'b0 || bus.m_pc !== 32'h0 || bus.m_alu_out !== 32'h0) begin
            errors++;
            $display("FAIL flush_over_stall actual valid=%b rw=%b fwd=%b rd=%b pc=%h alu=%h required all 0",
                     bus.m_valid, bus.m_reg_write, bus.m_forward_wb_m, bus.m_mem_read, bus.m_pc, bus.m_alu_out);
        end
    endtask

    task automatic test_misaligned_store();
        set_inputs(1, 0, 1, 0, 0, 0, 5'd0, 32'h102, 32'h55, 32'h80);
        step(1, 0, 0);
        checks++;
        if (bus.m_mem_write !== 1'b0 || bus.m_valid !== 1'b0 || bus.addr_exc !== 1'b1 ||
            bus.addr_exc_pc !== 32'h80 || bus.m_alu_out !== 32'h102) begin
            errors++;
            $display("FAIL misaligned_store actual wr=%b valid=%b exc=%b exc_pc=%h alu=%h required wr=0 valid=0 exc=1 exc_pc=80 alu=102",
                     bus.m_mem_write, bus.m_valid, bus.addr_exc, bus.addr_exc_pc, bus.m_alu_out);
        end
        set_inputs(1, 1, 0, 1, 1, 0, 5'd3, 32'h200, 32'h0, 32'h84);
        step(1, 0, 0);
        checks++;
        if (bus.addr_exc !== 1'b0 || bus.addr_exc_pc !== 32'h80 || bus.m_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL exc_pulse_end actual exc=%b exc_pc=%h rd=%b required exc=0 exc_pc=80 rd=1",
                     bus.addr_exc, bus.addr_exc_pc, bus.m_mem_read);
        end
    endtask

    task automatic test_back_to_back();
        set_inputs(1, 1, 0, 1, 1, 0, 5'd4, 32'h1, 32'h0, 32'h90);
        step(1, 0, 0);
        checks++;
        if (bus.addr_exc !== 1'b1 || bus.addr_exc_pc !== 32'h90 || bus.m_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first actual exc=%b exc_pc=%h rw=%b required exc=1 exc_pc=90 rw=0",
                     bus.addr_exc, bus.addr_exc_pc, bus.m_reg_write);
        end
        set_inputs(1, 0, 1, 0, 0, 0, 5'd4, 32'h3, 32'h0, 32'h94);
        step(1, 0, 0);
        checks++;
        if (bus.addr_exc !== 1'b1 || bus.addr_exc_pc !== 32'h94) begin
            errors++;
            $display("FAIL b2b_second actual exc=%b exc_pc=%h required exc=1 exc_pc=94",
                     bus.addr_exc, bus.addr_exc_pc);
        end
        // A stalled misaligned access must neither pulse nor capture its PC.
        set_inputs(1, 1, 0, 0, 0, 0, 5'd4, 32'h2, 32'h0, 32'h98);
        step(1, 1, 0);
        checks++;
        if (bus.addr_exc !== 1'b0 || bus.addr_exc_pc !== 32'h94) begin
            errors++;
            $display("FAIL stall_no_pulse actual exc=%b exc_pc=%h required exc=0 exc_pc=94",
                     bus.addr_exc, bus.addr_exc_pc);
        end
    endtask

    task automatic test_bubble_gating();
        set_inputs(0, 0, 1, 1, 1, 1, 5'd7, 32'h3, 32'h9, 32'hA0);
        step(1, 0, 0);
        checks++;
        if (bus.m_mem_write !== 1'b0 || bus.m_reg_write !== 1'b0 || bus.addr_exc !== 1'b0 ||
            bus.m_mem_to_reg !== 1'b0 || bus.m_alu_out !== 32'h3 || bus.m_pc !== 32'hA0) begin
            errors++;
            $display("FAIL bubble_gating actual wr=%b rw=%b exc=%b m2r=%b alu=%h pc=%h required wr=0 rw=0 exc=0 m2r=0 alu=3 pc=a0",
                     bus.m_mem_write, bus.m_reg_write, bus.addr_exc, bus.m_mem_to_reg, bus.m_alu_out, bus.m_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t act;
        set_inputs(1, 1, 0, 1, 0, 0, 5'd2, 32'h8, 32'h0, 32'h44);
        step(1, 0, 0);
        set_inputs(1, 1, 0, 1, 0, 0, 5'd2, 32'hC, 32'h0, 32'h48);
        step(1, 1, 0);
        step(0, 1, 0);
        act = sample();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall actual=%h expected=0", act);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            set_inputs($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            step($urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        model = '0;
        test_reset();
        test_normal_load();
        test_stall_flush();
        test_misaligned_store();
        test_back_to_back();
        test_bubble_gating();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
